// File: rtl/true_dual_port_bram.sv
// true_dual_port_bram: single-clock true dual-port RAM with byte-lane writes, selectable write mode and power-up clear
module true_dual_port_bram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BYTE_WIDTH = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ena,
  input  logic                               enb,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wea,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   web,
  input  logic [ADDR_WIDTH-1:0]              addra,
  input  logic [ADDR_WIDTH-1:0]              addrb,
  input  logic [DATA_WIDTH-1:0]              dina,
  input  logic [DATA_WIDTH-1:0]              dinb,
  output logic [DATA_WIDTH-1:0]              douta,
  output logic [DATA_WIDTH-1:0]              doutb,
  output logic                               douta_valid,
  output logic                               doutb_valid,
  output logic                               init_done
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic acc_a, acc_b, hit_a, hit_b;
  logic [DATA_WIDTH-1:0] rd_a, rd_b, mg_a, mg_b, nx_a, nx_b;
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= state == CLEAR ? cnt + 1'b1 : cnt;
    end
  always_comb state_nxt = (state == CLEAR && cnt == (ADDR_WIDTH+1)'(DEPTH - 1)) ? READY : state;
  always_comb init_done = state == READY && !rst;
  always_comb begin
    acc_a = ena && init_done;
    acc_b = enb && init_done;
    rd_a = mem[addra];
    rd_b = mem[addrb];
    mg_a = rd_a;
    mg_b = rd_b;
    for (int i = 0; i < NB; i++) begin
      mg_a[i*BYTE_WIDTH +: BYTE_WIDTH] = wea[i] ? dina[i*BYTE_WIDTH +: BYTE_WIDTH] : rd_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      mg_b[i*BYTE_WIDTH +: BYTE_WIDTH] = web[i] ? dinb[i*BYTE_WIDTH +: BYTE_WIDTH] : rd_b[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    nx_a = (|wea && WRITE_MODE == 1) ? mg_a : rd_a;
    nx_b = (|web && WRITE_MODE == 1) ? mg_b : rd_b;
    hit_a = acc_a && !(|wea && WRITE_MODE == 2);
    hit_b = acc_b && !(|web && WRITE_MODE == 2);
  end
  always_ff @(posedge clk)
    if (state == CLEAR) mem[cnt[ADDR_WIDTH-1:0]] <= '0;
    else
      for (int i = 0; i < NB; i++) begin
        if (acc_b && web[i]) mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (acc_a && wea[i]) mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
  if (READ_LATENCY == 2) begin : g_rl2
    logic pv_a, pv_b;
    logic [DATA_WIDTH-1:0] p_a, p_b;
    always_ff @(posedge clk)
      if (rst) begin
        pv_a <= 1'b0;
        pv_b <= 1'b0;
        p_a <= '0;
        p_b <= '0;
        douta <= '0;
        doutb <= '0;
        douta_valid <= 1'b0;
        doutb_valid <= 1'b0;
      end else begin
        pv_a <= hit_a;
        pv_b <= hit_b;
        p_a <= nx_a;
        p_b <= nx_b;
        douta_valid <= pv_a;
        doutb_valid <= pv_b;
        douta <= pv_a ? p_a : douta;
        doutb <= pv_b ? p_b : doutb;
      end
  end else begin : g_rl1
    always_ff @(posedge clk)
      if (rst) begin
        douta <= '0;
        doutb <= '0;
        douta_valid <= 1'b0;
        doutb_valid <= 1'b0;
      end else begin
        douta_valid <= hit_a;
        doutb_valid <= hit_b;
        douta <= hit_a ? nx_a : douta;
        doutb <= hit_b ? nx_b : doutb;
      end
  end
endmodule
